// File: rtl/fp_arb_pkg.sv
// Shared types for the two-requester FP32 add arbiter: response-register states,
// requester index type and operand width.
package fp_arb_pkg;

  localparam int FP32_W = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/fp32_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even, denormals kept.
// Zero latency; no flow control. Any NaN input, or inf + -inf, yields canonical qNaN 0x7FC00000.
module fp32_adder
  import fp_arb_pkg::*;
(
  input  logic [FP32_W-1:0] a_i,
  input  logic [FP32_W-1:0] b_i,
  output logic [FP32_W-1:0] sum_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, sl, ss, sub;
  logic [7:0]  el_raw, es_raw, el, es, d;
  logic [22:0] fl, fs;
  logic [26:0] xl, xs, al, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [24:0] rnd;
  logic        up;

  always_comb begin
    a_nan = (&a_i[30:23]) & (|a_i[22:0]);
    b_nan = (&b_i[30:23]) & (|b_i[22:0]);
    a_inf = (&a_i[30:23]) & ~(|a_i[22:0]);
    b_inf = (&b_i[30:23]) & ~(|b_i[22:0]);

    // Larger magnitude goes first so the aligned subtraction never borrows.
    swap   = b_i[30:0] > a_i[30:0];
    sl     = swap ? b_i[31]    : a_i[31];
    ss     = swap ? a_i[31]    : b_i[31];
    el_raw = swap ? b_i[30:23] : a_i[30:23];
    es_raw = swap ? a_i[30:23] : b_i[30:23];
    fl     = swap ? b_i[22:0]  : a_i[22:0];
    fs     = swap ? a_i[22:0]  : b_i[22:0];
    el     = (el_raw == 8'd0) ? 8'd1 : el_raw;
    es     = (es_raw == 8'd0) ? 8'd1 : es_raw;
    xl     = {|el_raw, fl, 3'b000};
    xs     = {|es_raw, fs, 3'b000};
    d      = el - es;
    sub    = sl ^ ss;

    if (d >= 8'd27) begin
      al = {26'd0, |xs};
    end else begin
      al    = xs >> d;
      al[0] = al[0] | (|(xs & ~({27{1'b1}} << d)));
    end

    sum = sub ? ({1'b0, xl} - {1'b0, al}) : ({1'b0, xl} + {1'b0, al});

    e  = {2'b00, el};
    lz = 5'd0;
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = e + 10'd1;
    end else begin
      lz = lzc27(sum[26:0]);
      if ({5'd0, lz} >= e) lz = 5'(e - 10'd1);
      norm = sum[26:0] << lz;
      e    = e - {5'd0, lz};
    end

    up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + {24'd0, up};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'd1;
    end

    if (a_nan | b_nan | (a_inf & b_inf & (a_i[31] ^ b_i[31]))) begin
      sum_o = QNAN;
    end else if (a_inf) begin
      sum_o = a_i;
    end else if (b_inf) begin
      sum_o = b_i;
    end else if (sum == 28'd0) begin
      sum_o = {~sub & sl, 31'd0};
    end else if (e >= 10'd255) begin
      sum_o = {sl, 8'hFF, 23'd0};
    end else begin
      sum_o = {sl, (rnd[23] ? e[7:0] : 8'd0), rnd[22:0]};
    end
  end

endmodule

// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter feeding one shared FP32 adder into a single response register.
// One cycle accept-to-rsp_valid; a held response (rsp_ready=0) blocks both requesters.
module fp32_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  rsp_state_e         state_q, state_d;
  req_id_t            last_grant_q, grant_id, id_q;
  logic               can_accept, accept;
  logic [FP32_W-1:0]  add_a, add_b, add_sum, result_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt0_q, cnt1_q;

  assign rsp_valid  = (state_q == FULL);
  assign can_accept = (state_q == EMPTY) | (rsp_ready & rsp_valid);

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid & req1_valid) grant_id = ~last_grant_q;
    else if (req1_valid)         grant_id = 1'b1;
  end

  // Gating with rst_n keeps both readies low for the whole reset window.
  assign accept     = rst_n & can_accept & (req0_valid | req1_valid);
  assign req0_ready = accept & (grant_id == 1'b0);
  assign req1_ready = accept & (grant_id == 1'b1);

  assign add_a = grant_id ? req1_a : req0_a;
  assign add_b = grant_id ? req1_b : req0_b;

  fp32_adder u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      id_q         <= 1'b0;
      tag_q        <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant_id;
        result_q     <= add_sum;
        id_q         <= grant_id;
        tag_q        <= grant_id ? req1_tag : req0_tag;
        if (!grant_id && !(&cnt0_q)) cnt0_q <= cnt0_q + CNT_W'(1);
        if (grant_id && !(&cnt1_q))  cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign rsp_result = result_q;
  assign rsp_id     = id_q;
  assign rsp_tag    = tag_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule
